// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : Shares the single byte-wide boot ROM read port between two
//            requesters (m0 = WASM section loader, m1 = instruction fetch).
//            One byte per transaction; the address is captured at grant and
//            completion is a 1-cycle ready (or err on watchdog abort) pulse
//            back to the granted requester.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            m0_read_en/m0_addr       - m0 request and byte address
//            m0_ready/m0_data/m0_err  - m0 completion pulse, held byte, abort
//            m1_*                     - identical set for m1
//            rom_addr/rom_read_en     - ROM request
//            rom_ready/rom_data_out   - ROM response
//            arb_busy/arb_grant       - transaction in flight / last winner
// Config   : ROM_ARB_RR_EN defined   -> strict alternation on ties
//            ROM_ARB_RR_EN undefined -> m0 fixed priority with BURST_MAX limit
// Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 255,
    parameter int BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_read_en,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_err,
    input  logic              m1_read_en,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_err,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    input  logic              rom_ready,
    input  logic [DATA_W-1:0] rom_data_out,
    output logic              arb_busy,
    output logic              arb_grant
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;

    // Watchdog counts 0..TIMEOUT-1 while waiting.
    localparam int              c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    logic [1:0]        r_state,       w_state_nxt;
    logic [ADDR_W-1:0] r_rom_addr,    w_rom_addr_nxt;
    logic              r_rom_read_en, w_rom_read_en_nxt;
    logic              r_grant,       w_grant_nxt;
    logic [DATA_W-1:0] r_m0_data,     w_m0_data_nxt;
    logic [DATA_W-1:0] r_m1_data,     w_m1_data_nxt;
    logic              r_m0_ready,    w_m0_ready_nxt;
    logic              r_m1_ready,    w_m1_ready_nxt;
    logic              r_m0_err,      w_m0_err_nxt;
    logic              r_m1_err,      w_m1_err_nxt;
    logic [c_WD_W-1:0] r_wd_cnt,      w_wd_cnt_nxt;
    logic              w_win;

`ifndef ROM_ARB_RR_EN
    localparam int                c_BC_W      = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
    localparam logic [c_BC_W-1:0] c_BURST_MAX = c_BC_W'(BURST_MAX);
    logic [c_BC_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
`endif

    // Winner when the arbiter is idle. A lone requester always wins; only
    // ties depend on the arbitration mode.
    always_comb begin
        w_win = m1_read_en;
        if (m0_read_en && m1_read_en) begin
`ifdef ROM_ARB_RR_EN
            w_win = ~r_grant;
`else
            // m0 keeps winning until it has taken BURST_MAX grants in a row
            // over a waiting m1.
            w_win = (r_burst_cnt == c_BURST_MAX);
`endif
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rom_addr_nxt    = r_rom_addr;
        w_rom_read_en_nxt = r_rom_read_en;
        w_grant_nxt       = r_grant;
        w_m0_data_nxt     = r_m0_data;
        w_m1_data_nxt     = r_m1_data;
        w_m0_ready_nxt    = 1'b0;
        w_m1_ready_nxt    = 1'b0;
        w_m0_err_nxt      = 1'b0;
        w_m1_err_nxt      = 1'b0;
        w_wd_cnt_nxt      = r_wd_cnt;
`ifndef ROM_ARB_RR_EN
        w_burst_cnt_nxt   = r_burst_cnt;
`endif

        case (r_state)
            c_ST_IDLE: begin
                if (m0_read_en || m1_read_en) begin
                    w_grant_nxt       = w_win;
                    w_rom_addr_nxt    = w_win ? m1_addr : m0_addr;
                    w_rom_read_en_nxt = 1'b1;
                    w_wd_cnt_nxt      = '0;
                    w_state_nxt       = c_ST_WAIT;
`ifndef ROM_ARB_RR_EN
                    // Only m0 grants over a pending m1 extend the burst.
                    if (!w_win && m1_read_en) begin
                        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    end else begin
                        w_burst_cnt_nxt = '0;
                    end
`endif
                end
            end

            c_ST_WAIT: begin
                if (rom_ready) begin
                    if (r_grant) begin
                        w_m1_data_nxt  = rom_data_out;
                        w_m1_ready_nxt = 1'b1;
                    end else begin
                        w_m0_data_nxt  = rom_data_out;
                        w_m0_ready_nxt = 1'b1;
                    end
                    w_rom_read_en_nxt = 1'b0;
                    w_state_nxt       = c_ST_RELEASE;
                end else if (r_wd_cnt == c_WD_LAST) begin
                    w_m1_err_nxt      = r_grant;
                    w_m0_err_nxt      = ~r_grant;
                    w_rom_read_en_nxt = 1'b0;
                    w_state_nxt       = c_ST_RELEASE;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                end
            end

            c_ST_RELEASE: begin
                // Let the ROM drop its ready before the next grant so a stale
                // ready can never complete the following transaction.
                if (!rom_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt       = c_ST_IDLE;
                w_rom_read_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_rom_addr    <= '0;
            r_rom_read_en <= 1'b0;
            r_grant       <= 1'b1;   // m0 wins the first alternation decision
            r_m0_data     <= '0;
            r_m1_data     <= '0;
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_m0_err      <= 1'b0;
            r_m1_err      <= 1'b0;
            r_wd_cnt      <= '0;
`ifndef ROM_ARB_RR_EN
            r_burst_cnt   <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_rom_addr    <= w_rom_addr_nxt;
            r_rom_read_en <= w_rom_read_en_nxt;
            r_grant       <= w_grant_nxt;
            r_m0_data     <= w_m0_data_nxt;
            r_m1_data     <= w_m1_data_nxt;
            r_m0_ready    <= w_m0_ready_nxt;
            r_m1_ready    <= w_m1_ready_nxt;
            r_m0_err      <= w_m0_err_nxt;
            r_m1_err      <= w_m1_err_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
`ifndef ROM_ARB_RR_EN
            r_burst_cnt   <= w_burst_cnt_nxt;
`endif
        end
    end

    assign rom_addr    = r_rom_addr;
    assign rom_read_en = r_rom_read_en;
    assign m0_ready    = r_m0_ready;
    assign m0_data     = r_m0_data;
    assign m0_err      = r_m0_err;
    assign m1_ready    = r_m1_ready;
    assign m1_data     = r_m1_data;
    assign m1_err      = r_m1_err;
    assign arb_busy    = (r_state != c_ST_IDLE);
    assign arb_grant   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_port_arbiter
// Purpose  : Directed self-checking bench for rom_port_arbiter. A small ROM
//            model answers rom_lat cycles after rom_read_en rises with
//            data = addr[7:0] ^ 0x38 (so 0x30 -> 0x08), or never when
//            rom_dead is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

    localparam int c_ADDR_W    = 32;
    localparam int c_DATA_W    = 8;
    localparam int c_TIMEOUT   = 8;
    localparam int c_BURST_MAX = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                m0_read_en, m1_read_en;
    logic [c_ADDR_W-1:0] m0_addr, m1_addr;
    logic                m0_ready, m1_ready, m0_err, m1_err;
    logic [c_DATA_W-1:0] m0_data, m1_data;
    logic [c_ADDR_W-1:0] rom_addr;
    logic                rom_read_en, rom_ready;
    logic [c_DATA_W-1:0] rom_data_out;
    logic                arb_busy, arb_grant;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    always #5 clk = ~clk;

    // ROM model
    int   rom_lat  = 1;
    logic rom_dead = 1'b0;
    int   rom_cnt  = 0;

    always @(posedge clk) rom_cnt <= rom_read_en ? rom_cnt + 1 : 0;
    assign rom_ready    = rom_read_en && !rom_dead && (rom_cnt >= rom_lat);
    assign rom_data_out = rom_addr[7:0] ^ 8'h38;

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return a[7:0] ^ 8'h38;
    endfunction

    rom_port_arbiter #(
        .ADDR_W   (c_ADDR_W),
        .DATA_W   (c_DATA_W),
        .TIMEOUT  (c_TIMEOUT),
        .BURST_MAX(c_BURST_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_read_en  (m0_read_en),
        .m0_addr     (m0_addr),
        .m0_ready    (m0_ready),
        .m0_data     (m0_data),
        .m0_err      (m0_err),
        .m1_read_en  (m1_read_en),
        .m1_addr     (m1_addr),
        .m1_ready    (m1_ready),
        .m1_data     (m1_data),
        .m1_err      (m1_err),
        .rom_addr    (rom_addr),
        .rom_read_en (rom_read_en),
        .rom_ready   (rom_ready),
        .rom_data_out(rom_data_out),
        .arb_busy    (arb_busy),
        .arb_grant   (arb_grant)
    );

    // Invariants watched every cycle outside reset.
    logic                prev_en   = 1'b0;
    logic [c_ADDR_W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (m0_ready && m1_ready) viol++;
            if ((m0_ready || m1_ready) && (m0_err || m1_err)) viol++;
            if (rom_read_en && prev_en && (rom_addr != prev_addr)) viol++;
        end
        prev_en   = rom_read_en;
        prev_addr = rom_addr;
    end

    task automatic test_reset();
        rst = 1'b1; m0_read_en = 1'b0; m1_read_en = 1'b0;
        m0_addr = '0; m1_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (rom_read_en !== 1'b0 || rom_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_rom: rom_read_en=%b rom_addr=%h expected 0/00000000", rom_read_en, rom_addr);
        end
        checks++;
        if (arb_grant !== 1'b1) begin
            failures++; $display("FAIL reset_grant: got %b expected 1", arb_grant);
        end
        checks++;
        if (arb_busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b expected 0", arb_busy);
        end
        checks++;
        if ({m0_ready, m0_err, m1_ready, m1_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses: got %b expected 0000", {m0_ready, m0_err, m1_ready, m1_err});
        end
        checks++;
        if (m0_data !== 8'h00 || m1_data !== 8'h00) begin
            failures++; $display("FAIL reset_data: m0=%h m1=%h expected 00/00", m0_data, m1_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int lat;
        bit seen, m1_touched;
        rom_lat = 2; m0_addr = 32'h30; m0_read_en = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_read_en !== 1'b1 || rom_addr !== 32'h30 || arb_grant !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: en=%b addr=%h grant=%b expected 1/00000030/0", rom_read_en, rom_addr, arb_grant);
        end
        m0_read_en = 1'b0;
        lat = 0; seen = 0; m1_touched = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (m1_ready || m1_err) m1_touched = 1;
            if (m0_ready) seen = 1;
        end
        checks++;
        if (!seen || lat != 3) begin
            failures++; $display("FAIL single_latency: seen=%0d cycles=%0d expected 1/3", seen, lat);
        end
        checks++;
        if (m0_data !== 8'h08) begin
            failures++; $display("FAIL single_data: got %h expected 08", m0_data);
        end
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b0 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse_end: m0_ready=%b busy=%b expected 0/0", m0_ready, arb_busy);
        end
        checks++;
        if (m1_touched || m1_data !== 8'h00) begin
            failures++; $display("FAIL single_m1_untouched: touched=%0d m1_data=%h expected 0/00", m1_touched, m1_data);
        end
    endtask

    task automatic test_timeout();
        int n, extra_err;
        rom_dead = 1'b1; rom_lat = 1; m0_addr = 32'h40; m0_read_en = 1'b1;
        @(negedge clk);
        m0_read_en = 1'b0;
        n = 0;
        while (rom_read_en === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != c_TIMEOUT) begin
            failures++; $display("FAIL timeout_wait_cycles: got %0d expected %0d", n, c_TIMEOUT);
        end
        checks++;
        if (m0_err !== 1'b1 || m0_ready !== 1'b0 || m1_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_pulse: m0_err=%b m0_ready=%b m1_err=%b expected 1/0/0", m0_err, m0_ready, m1_err);
        end
        checks++;
        if (m0_data !== 8'h08) begin
            failures++; $display("FAIL timeout_data_held: got %h expected 08", m0_data);
        end
        extra_err = 0;
        repeat (6) begin
            @(negedge clk);
            if (m0_err || m1_err || m0_ready) extra_err++;
        end
        checks++;
        if (extra_err != 0 || arb_busy !== 1'b0) begin
            failures++; $display("FAIL timeout_single_pulse: extra=%0d busy=%b expected 0/0", extra_err, arb_busy);
        end
        rom_dead = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit touched;
        rom_dead = 1'b1; m1_addr = 32'h55; m1_read_en = 1'b1;
        @(negedge clk);
        m1_read_en = 1'b0;
        checks++;
        if (rom_read_en !== 1'b1 || arb_grant !== 1'b1 || rom_addr !== 32'h55) begin
            failures++;
            $display("FAIL rstwait_grant: en=%b grant=%b addr=%h expected 1/1/00000055", rom_read_en, arb_grant, rom_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_read_en !== 1'b0 || arb_busy !== 1'b0) begin
            failures++; $display("FAIL rstwait_idle: en=%b busy=%b expected 0/0", rom_read_en, arb_busy);
        end
        rst = 1'b0; rom_dead = 1'b0;
        touched = 0;
        repeat (12) begin
            @(negedge clk);
            if (m1_ready || m1_err) touched = 1;
        end
        checks++;
        if (touched) begin
            failures++; $display("FAIL rstwait_no_pulse: m1 pulse seen=1 expected 0");
        end
    endtask

    task automatic test_tie();
        logic [33:0] got, exp;
        int n_txn, k, cyc, last, bad_gap, bad_data, dbl;
`ifdef ROM_ARB_RR_EN
        n_txn = 8;
        exp   = 34'h0_0000_00AA;          // m0,m1,m0,m1,... from bit 0
`else
        n_txn = 34;
        exp   = 34'h0;
        exp[16] = 1'b1;                    // 16 m0 grants, then m1, repeat
        exp[33] = 1'b1;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rom_lat = 1; m0_addr = 32'h31; m1_addr = 32'h90;
        m0_read_en = 1'b1; m1_read_en = 1'b1;
        got = '0; k = 0; cyc = 0; last = -1; bad_gap = 0; bad_data = 0; dbl = 0;
        while (k < n_txn && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (m0_ready && m1_ready) dbl++;
            if (m0_ready || m1_ready) begin
                got[k] = m1_ready;
                if (m1_ready ? (m1_data !== 8'hA8) : (m0_data !== 8'h09)) bad_data++;
                if (last >= 0 && (cyc - last) != 4) bad_gap++;
                last = cyc;
                k++;
            end
        end
        m0_read_en = 1'b0; m1_read_en = 1'b0;
        checks++;
        if (k != n_txn) begin
            failures++; $display("FAIL tie_count: got %0d transactions expected %0d", k, n_txn);
        end
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL tie_order: got %b expected %b", got, exp);
        end
        checks++;
        if (dbl != 0 || bad_data != 0) begin
            failures++; $display("FAIL tie_data: double_ready=%0d bad_data=%0d expected 0/0", dbl, bad_data);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++; $display("FAIL tie_spacing: bad gaps=%0d expected 0", bad_gap);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k, cyc, last, bad_gap, bad_data, m1_seen;
        rom_lat = 1; m0_addr = 32'h30; m0_read_en = 1'b1;
        k = 0; cyc = 0; last = -1; bad_gap = 0; bad_data = 0; m1_seen = 0;
        while (k < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m1_ready) m1_seen++;
            if (m0_ready) begin
                if (m0_data !== rom_byte(32'h30 + 32'(k))) begin
                    bad_data++;
                    $display("FAIL stream_byte%0d: got %h expected %h", k, m0_data, rom_byte(32'h30 + 32'(k)));
                end
                if (last >= 0 && (cyc - last) != 4) bad_gap++;
                last = cyc;
                k++;
                if (k < 8) m0_addr = 32'h30 + 32'(k);
                else       m0_read_en = 1'b0;
            end
        end
        m0_read_en = 1'b0;
        checks++;
        if (k != 8 || m1_seen != 0) begin
            failures++; $display("FAIL stream_count: got %0d bytes m1=%0d expected 8/0", k, m1_seen);
        end
        checks++;
        if (bad_data != 0) begin
            failures++; $display("FAIL stream_data: bad bytes=%0d expected 0", bad_data);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++; $display("FAIL stream_spacing: bad gaps=%0d expected 0", bad_gap);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL invariants: violations=%0d expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_timeout();
        test_reset_mid_wait();
        test_tie();
        test_back_to_back();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
